// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared defaults, word type and slice ordering helper for the instruction assembler
package instr_pkg;
  localparam int DATA_W = 8;
  localparam int BEATS  = 2;
  localparam int DEPTH  = 2;
  localparam int WORD_W = DATA_W * BEATS;

  typedef logic [WORD_W-1:0] instr_word_t;

  // Maps a beat number to the slice it fills inside the assembled word.
  function automatic int slice_index(input logic [2:0] beat, input int beats, input int msb_first);
    return (msb_first != 0) ? (beats - 1 - int'(beat)) : int'(beat);
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - DEPTH-entry synchronous word queue with full/empty flags
module instr_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk1,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  // A pop on the same edge frees the slot, so a full queue still takes the push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= wdata;
    end
  end
endmodule

// File: rtl/instr_assembler.sv
// rtl/instr_assembler.sv - packs BEATS bus beats into instruction words and queues them
module instr_assembler #(
  parameter int DATA_W    = instr_pkg::DATA_W,
  parameter int BEATS     = instr_pkg::BEATS,
  parameter int MSB_FIRST = 1,
  parameter int DEPTH     = instr_pkg::DEPTH
) (
  input  logic                    clk1,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [DATA_W-1:0]       data,
  input  logic                    flush,
  input  logic                    instr_ready,
  output logic [DATA_W*BEATS-1:0] instr_out,
  output logic                    instr_valid,
  output logic                    busy,
  output logic [2:0]              beat_cnt,
  output logic                    overflow
);
  import instr_pkg::*;

  localparam int WW = DATA_W * BEATS;

  logic [2:0]    beat_cnt_q, beat_cnt_d;
  logic [WW-1:0] part_q, part_d;
  logic          overflow_q, overflow_d;
  logic          push;
  logic          fifo_full, fifo_empty;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    part_d     = part_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    if (flush) begin
      beat_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (ena) begin
      for (int i = 0; i < BEATS; i++) begin
        if (i == slice_index(beat_cnt_q, BEATS, MSB_FIRST)) part_d[i*DATA_W +: DATA_W] = data;
      end
      if (beat_cnt_q == 3'(BEATS-1)) begin
        push       = 1'b1;
        beat_cnt_d = '0;
        if (fifo_full && !instr_ready) overflow_d = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 3'd1;
      end
    end else begin
      // Stale slices need no clearing: every slice is rewritten before the next push.
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      beat_cnt_q <= '0;
      part_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      part_q     <= part_d;
      overflow_q <= overflow_d;
    end
  end

  instr_fifo #(.W(WW), .DEPTH(DEPTH)) u_fifo (
    .clk1  (clk1),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (part_d),
    .pop   (instr_ready),
    .head  (instr_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign busy        = (beat_cnt_q != 3'd0);
  assign beat_cnt    = beat_cnt_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_instr_assembler.sv
// tb/tb_instr_assembler.sv - scoreboard bench for instr_assembler in two configurations
module tb_instr_assembler;
  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst;
  logic        a_ena, a_flush, a_ready;
  logic [7:0]  a_data;
  logic [15:0] a_out;
  logic        a_valid, a_busy, a_ovf;
  logic [2:0]  a_cnt;

  logic        b_ena, b_flush, b_ready;
  logic [7:0]  b_data;
  logic [31:0] b_out;
  logic        b_valid, b_busy, b_ovf;
  logic [2:0]  b_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] a_exp[$];
  logic [31:0] b_exp[$];

  instr_assembler dut_a (
    .clk1(clk1), .rst(rst), .ena(a_ena), .data(a_data), .flush(a_flush),
    .instr_ready(a_ready), .instr_out(a_out), .instr_valid(a_valid),
    .busy(a_busy), .beat_cnt(a_cnt), .overflow(a_ovf)
  );

  instr_assembler #(.DATA_W(8), .BEATS(4), .MSB_FIRST(0), .DEPTH(2)) dut_b (
    .clk1(clk1), .rst(rst), .ena(b_ena), .data(b_data), .flush(b_flush),
    .instr_ready(b_ready), .instr_out(b_out), .instr_valid(b_valid),
    .busy(b_busy), .beat_cnt(b_cnt), .overflow(b_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: head word must match the scoreboard while held, and on every pop.
  always @(negedge clk1) begin
    if (!rst && !a_flush && a_valid) begin
      if (a_exp.size() == 0) chk("a_unexpected_word", 32'(a_out), 32'hFFFF_FFFF);
      else if (a_ready)      chk("a_pop", 32'(a_out), a_exp.pop_front());
      else                   chk("a_hold", 32'(a_out), a_exp[0]);
    end
  end

  always @(negedge clk1) begin
    if (!rst && !b_flush && b_valid) begin
      if (b_exp.size() == 0) chk("b_unexpected_word", b_out, 32'hFFFF_FFFF);
      else if (b_ready)      chk("b_pop", b_out, b_exp.pop_front());
      else                   chk("b_hold", b_out, b_exp[0]);
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic a_word(input logic [15:0] w, input logic kept);
    a_ena  = 1'b1;
    a_data = w[15:8];
    step();
    a_data = w[7:0];
    if (kept) a_exp.push_back(32'(w));
    step();
    a_ena = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_ena = 0; a_flush = 0; a_ready = 0; a_data = 0;
    b_ena = 0; b_flush = 0; b_ready = 0; b_data = 0;
    step();
    step();
    rst = 1'b0;
    chk("rst_cnt", 32'(a_cnt), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_out", 32'(a_out), 0);
    chk("rst_ovf", 32'(a_ovf), 0);

    // Two beats, MSB first
    a_ena = 1; a_data = 8'h12; step();
    chk("mid_busy", 32'(a_busy), 1);
    chk("mid_cnt", 32'(a_cnt), 1);
    chk("mid_valid", 32'(a_valid), 0);
    a_data = 8'h34; a_exp.push_back(32'h1234); step();
    a_ena = 0;
    chk("done_busy", 32'(a_busy), 0);
    chk("done_valid", 32'(a_valid), 1);
    chk("done_out", 32'(a_out), 32'h1234);
    step();
    chk("stable_out", 32'(a_out), 32'h1234);
    a_ready = 1; step(); a_ready = 0;
    chk("popped_valid", 32'(a_valid), 0);
    chk("popped_out", 32'(a_out), 0);

    // Partial word abandoned by an ena=0 edge
    a_ena = 1; a_data = 8'h56; step();
    a_ena = 0; step();
    chk("abort_cnt", 32'(a_cnt), 0);
    chk("abort_valid", 32'(a_valid), 0);
    a_word(16'h9ABC, 1);
    chk("abort_word", 32'(a_out), 32'h9ABC);
    a_ready = 1; step(); a_ready = 0;
    chk("abort_empty", 32'(a_valid), 0);

    // Overflow on third word into a 2-deep queue
    a_word(16'h1234, 1);
    a_word(16'h5678, 1);
    chk("full_no_ovf", 32'(a_ovf), 0);
    a_word(16'h9ABC, 0);
    chk("ovf_set", 32'(a_ovf), 1);
    chk("ovf_head", 32'(a_out), 32'h1234);
    a_ready = 1; step(); step(); a_ready = 0;
    chk("ovf_drained", 32'(a_valid), 0);
    chk("ovf_sticky", 32'(a_ovf), 1);
    a_flush = 1; step(); a_flush = 0;
    chk("ovf_flushed", 32'(a_ovf), 0);

    // Push and pop on the same edge with a full queue
    a_word(16'h1111, 1);
    a_word(16'h2222, 1);
    a_ena = 1; a_data = 8'h33; step();
    a_data = 8'h44; a_ready = 1; a_exp.push_back(32'h3344); step();
    a_ena = 0; a_ready = 0;
    chk("pp_no_ovf", 32'(a_ovf), 0);
    chk("pp_head", 32'(a_out), 32'h2222);
    chk("pp_valid", 32'(a_valid), 1);
    step();
    a_ready = 1; step(); step(); a_ready = 0;
    chk("pp_drained", 32'(a_valid), 0);

    // Flush mid-word with a word queued
    a_word(16'hABCD, 1);
    a_ena = 1; a_data = 8'h77; step();
    a_flush = 1; a_data = 8'h88; a_ready = 1; a_exp.delete(); step();
    a_flush = 0; a_ena = 0; a_ready = 0;
    chk("flush_cnt", 32'(a_cnt), 0);
    chk("flush_valid", 32'(a_valid), 0);
    chk("flush_out", 32'(a_out), 0);
    step();
    chk("flush_stays_empty", 32'(a_valid), 0);

    // Reset with a word queued and a beat in progress
    a_word(16'hEF01, 1);
    a_ena = 1; a_data = 8'h22; step();
    rst = 1; a_exp.delete(); step();
    rst = 0; a_ena = 0;
    chk("rst2_cnt", 32'(a_cnt), 0);
    chk("rst2_valid", 32'(a_valid), 0);
    chk("rst2_out", 32'(a_out), 0);

    // Four beats, LSB first
    b_ena = 1;
    b_data = 8'hAA; step();
    b_data = 8'hBB; step();
    b_data = 8'hCC; step();
    chk("b_cnt3", 32'(b_cnt), 3);
    chk("b_busy", 32'(b_busy), 1);
    b_data = 8'hDD; b_exp.push_back(32'hDDCC_BBAA); step();
    b_ena = 0;
    chk("b_word", b_out, 32'hDDCC_BBAA);
    chk("b_cnt0", 32'(b_cnt), 0);
    b_ready = 1; step(); b_ready = 0;
    chk("b_empty", 32'(b_valid), 0);

    chk("a_scoreboard_empty", 32'(a_exp.size()), 0);
    chk("b_scoreboard_empty", 32'(b_exp.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_assembler.md
INSTR_ASSEMBLER -- requirements
Module: instr_assembler

Interface
REQ-001 Parameter DATA_W, default 8, meaning bus byte width in bits.
REQ-002 Parameter BEATS, default 2, meaning bus beats per instruction word; legal range 2..8.
REQ-003 Parameter MSB_FIRST, default 1, meaning 1: first beat lands in the most-significant slice; 0: first beat lands in the least-significant slice.
REQ-004 Parameter DEPTH, default 2, meaning output queue entries; power of two, 2..8.
REQ-005 clk1  input  1  clock; all state changes on posedge clk1.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 ena  input  1  load_ir; current bus beat belongs to an instruction.
REQ-008 data  input  DATA_W  bus data.
REQ-009 flush  input  1  discard the partial word and all queued words.
REQ-010 instr_ready  input  1  consumer accepts the head word.
REQ-011 instr_out  output  DATA_W*BEATS  queue head word.
REQ-012 instr_valid  output  1  instr_out holds a valid word.
REQ-013 busy  output  1  partial word in progress (beat count nonzero).
REQ-014 beat_cnt  output  3  beats captured toward the current word.
REQ-015 overflow  output  1  sticky; a completed word was dropped.

Function
REQ-016 Beat counter runs 0..BEATS-1; each clk1 edge with ena=1 captures data into slice beat_cnt, ordered per MSB_FIRST, and increments the counter.
REQ-017 Edge with ena=1 and beat_cnt=BEATS-1 completes the word, pushes it to the queue, and wraps beat_cnt to 0.
REQ-018 Edge with ena=0 returns beat_cnt to 0 and discards the partial word; queue unaffected.
REQ-019 Latency: word completed at edge N into an empty queue gives instr_valid=1 and the word on instr_out from edge N onward; no combinational path from data to instr_out.
REQ-020 Pop occurs on an edge with instr_valid=1 and instr_ready=1; instr_ready while instr_valid=0 has no effect.
REQ-021 instr_out and instr_valid are stable while instr_valid=1 and instr_ready=0.
REQ-022 Simultaneous push and pop at any occupancy, including full, both succeed; occupancy unchanged.
REQ-023 Push onto a full queue without a pop drops the new word, sets overflow, and keeps queue contents unchanged.
REQ-024 overflow clears only on rst or flush.
REQ-025 flush has priority over ena and instr_ready: beat_cnt=0, queue empty, overflow=0 after the edge; data on that edge is ignored.
REQ-026 Queue order is FIFO; read and write pointers wrap modulo DEPTH.
REQ-027 instr_out is 0 whenever the queue is empty.

Reset
REQ-028 On an rst edge, beat_cnt=0, busy=0, queue empty, instr_valid=0, instr_out=0, and overflow=0.
REQ-029 rst has priority over flush, ena, and instr_ready; rst mid-word or mid-queue discards everything.

Structure
REQ-030 A shared package instr_pkg holds the default constants DATA_W, BEATS, and DEPTH, and the instr_word_t width definition.
REQ-031 One sub-module, instr_fifo, implements the DEPTH-entry synchronous queue with full/empty flags; instr_assembler owns the beat counter and the slice packing.

Verification
REQ-032 Defaults; ena=1 with data 0x12 then 0x34; instr_ready=0 -> instr_out=0x1234 and instr_valid=1 after the second edge; busy=1 only between the beats.
REQ-033 MSB_FIRST=0, BEATS=4; beats 0xAA,0xBB,0xCC,0xDD -> instr_out=0xDDCCBBAA.
REQ-034 ena=1 with data 0x56, then ena=0 for one edge, then beats 0x9A and 0xBC -> single word 0x9ABC; 0x56 discarded.
REQ-035 Three words with instr_ready=0 and DEPTH=2 -> first two words retained in order, overflow=1; then instr_ready=1 for 2 edges -> 0x1234 then the second word pop; overflow stays 1 until flush.
REQ-036 Queue full and instr_ready=1 on the completing edge -> no overflow; occupancy stays 2; the new word is the next-after-head.
REQ-037 flush asserted with ena=1 after one beat, and rst asserted with a word queued -> beat_cnt=0, instr_valid=0, and instr_out=0 after each edge.
